// File: rtl/exe_mem_stage_buf_if.sv
// EXE -> MEM handshake bundle for exe_mem_stage_buf.
// The slave modport is the buffer; the master modport is the surrounding EXE/MEM logic.
interface exe_mem_stage_buf_if #(
   parameter int REG_LEN  = 32,
   parameter int DEST_LEN = 4
);
   logic                exe_valid;
   logic                exe_ready;
   logic                flush;
   logic [REG_LEN-1:0]  alu_result;
   logic [3:0]          alu_status;
   logic                s_bit;
   logic                wb_en;
   logic                mem_r_en;
   logic                mem_w_en;
   logic [DEST_LEN-1:0] dest;
   logic [REG_LEN-1:0]  val_rm;

   logic                mem_valid;
   logic                mem_ready;
   logic [REG_LEN-1:0]  mem_alu_result;
   logic [REG_LEN-1:0]  mem_val_rm;
   logic                mem_wb_en;
   logic                mem_r_en_o;
   logic                mem_w_en_o;
   logic [DEST_LEN-1:0] mem_dest;

   modport slave (
      input  exe_valid, flush, alu_result, alu_status, s_bit,
             wb_en, mem_r_en, mem_w_en, dest, val_rm, mem_ready,
      output exe_ready, mem_valid, mem_alu_result, mem_val_rm,
             mem_wb_en, mem_r_en_o, mem_w_en_o, mem_dest
   );

   modport master (
      output exe_valid, flush, alu_result, alu_status, s_bit,
             wb_en, mem_r_en, mem_w_en, dest, val_rm, mem_ready,
      input  exe_ready, mem_valid, mem_alu_result, mem_val_rm,
             mem_wb_en, mem_r_en_o, mem_w_en_o, mem_dest
   );
endinterface

// File: rtl/exe_mem_stage_buf.sv
// EXE->MEM two-entry skid buffer with the NZCV status register.
// Optional stall counter enabled by defining EXE_MEM_STALL_CNT_EN.
module exe_mem_stage_buf #(
   parameter int REG_LEN  = 32,
   parameter int DEST_LEN = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   exe_mem_stage_buf_if.slave   bus,
   output logic [3:0]           status_reg,
   output logic                 carry_out,
   output logic [15:0]          stall_count
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   typedef struct packed {
      logic [REG_LEN-1:0]  alu_result;
      logic [REG_LEN-1:0]  val_rm;
      logic [DEST_LEN-1:0] dest;
      logic                wb_en;
      logic                r_en;
      logic                w_en;
   } entry_t;

   state_t state_reg, state_next;
   logic   exe_ready_reg;
   entry_t head_reg, skid_reg, in_entry;
   logic   accept, drain, load_head, load_skid, promote;

   assign accept = bus.exe_valid & exe_ready_reg & ~bus.flush;
   assign drain  = (state_reg != EMPTY) & bus.mem_ready;

   always_comb begin
      in_entry            = '0;
      in_entry.alu_result = bus.alu_result;
      in_entry.val_rm     = bus.val_rm;
      in_entry.dest       = bus.dest;
      in_entry.wb_en      = bus.wb_en;
      in_entry.r_en       = bus.mem_r_en;
      in_entry.w_en       = bus.mem_w_en;
   end

   always_comb begin
      state_next = state_reg;
      load_head  = 1'b0;
      load_skid  = 1'b0;
      promote    = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next = ONE;
               load_head  = 1'b1;
            end
         end
         ONE: begin
            if (accept && drain) begin
               load_head = 1'b1;
            end else if (accept) begin
               state_next = TWO;
               load_skid  = 1'b1;
            end else if (drain) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            // exe_ready is low here, so the only event is a drain.
            if (drain) begin
               state_next = ONE;
               promote    = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= EMPTY;
         exe_ready_reg <= 1'b1;
         head_reg      <= '0;
         skid_reg      <= '0;
         status_reg    <= 4'b0;
      end else begin
         state_reg     <= state_next;
         exe_ready_reg <= (state_next != TWO);
         if (load_head) begin
            head_reg <= in_entry;
         end else if (promote) begin
            head_reg <= skid_reg;
         end
         if (load_skid) begin
            skid_reg <= in_entry;
         end
         // Status follows the accept handshake, so a held EXE instruction updates it once.
         if (accept && bus.s_bit) begin
            status_reg <= bus.alu_status;
         end
      end
   end

   assign carry_out          = status_reg[2];
   assign bus.exe_ready      = exe_ready_reg;
   assign bus.mem_valid      = (state_reg != EMPTY);
   assign bus.mem_alu_result = head_reg.alu_result;
   assign bus.mem_val_rm     = head_reg.val_rm;
   assign bus.mem_dest       = head_reg.dest;
   assign bus.mem_wb_en      = head_reg.wb_en & bus.mem_valid;
   assign bus.mem_r_en_o     = head_reg.r_en  & bus.mem_valid;
   assign bus.mem_w_en_o     = head_reg.w_en  & bus.mem_valid;

`ifdef EXE_MEM_STALL_CNT_EN
   logic [15:0] stall_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_reg <= 16'h0;
      end else if (bus.exe_valid && !exe_ready_reg && !bus.flush && stall_cnt_reg != 16'hFFFF) begin
         stall_cnt_reg <= stall_cnt_reg + 16'h1;
      end
   end

   assign stall_count = stall_cnt_reg;
`else
   assign stall_count = 16'h0;
`endif
endmodule

// File: tb/tb_exe_mem_stage_buf.sv
// Directed bench for exe_mem_stage_buf: vector table plus stall-count and mid-run reset sequences.
module tb_exe_mem_stage_buf;
   logic        clk;
   logic        rst;
   logic [3:0]  status_reg;
   logic        carry_out;
   logic [15:0] stall_count;
   int          n_cmp;
   int          n_err;

   exe_mem_stage_buf_if #(.REG_LEN(32), .DEST_LEN(4)) bus ();

   exe_mem_stage_buf #(.REG_LEN(32), .DEST_LEN(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .status_reg  (status_reg),
      .carry_out   (carry_out),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ev;
      logic        fl;
      logic        mr;
      logic        sb;
      logic [3:0]  ast;
      logic [31:0] res;
      logic [3:0]  dst;
      logic        wb;
      logic        re;
      logic        we;
      logic        x_mv;
      logic        x_er;
      logic [31:0] x_res;
      logic [3:0]  x_dst;
      logic        x_wb;
      logic        x_re;
      logic        x_we;
      logic [3:0]  x_st;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.exe_valid  = v.ev;
      bus.flush      = v.fl;
      bus.mem_ready  = v.mr;
      bus.s_bit      = v.sb;
      bus.alu_status = v.ast;
      bus.alu_result = v.res;
      bus.val_rm     = ~v.res;
      bus.dest       = v.dst;
      bus.wb_en      = v.wb;
      bus.mem_r_en   = v.re;
      bus.mem_w_en   = v.we;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      //        ev    fl    mr    sb    ast      res    dst   wb    re    we  | mv    er    res    dst   wb    re    we    st
      vecs[0]  = '{1'b1,1'b0,1'b1,1'b0,4'b0000,32'h05,4'd3,1'b1,1'b0,1'b0, 1'b1,1'b1,32'h05,4'd3,1'b1,1'b0,1'b0,4'b0000};
      vecs[1]  = '{1'b1,1'b0,1'b1,1'b1,4'b0100,32'h07,4'd4,1'b1,1'b0,1'b0, 1'b1,1'b1,32'h07,4'd4,1'b1,1'b0,1'b0,4'b0100};
      vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,4'b1111,32'h09,4'd5,1'b0,1'b1,1'b0, 1'b1,1'b1,32'h09,4'd5,1'b0,1'b1,1'b0,4'b0100};
      vecs[3]  = '{1'b1,1'b1,1'b0,1'b1,4'b1000,32'hAA,4'd6,1'b1,1'b0,1'b0, 1'b1,1'b1,32'h09,4'd5,1'b0,1'b1,1'b0,4'b0100};
      vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,4'b0000,32'h00,4'd0,1'b0,1'b0,1'b0, 1'b0,1'b1,32'h00,4'd0,1'b0,1'b0,1'b0,4'b0100};
      vecs[5]  = '{1'b1,1'b0,1'b0,1'b1,4'b0001,32'h11,4'd1,1'b1,1'b0,1'b1, 1'b1,1'b1,32'h11,4'd1,1'b1,1'b0,1'b1,4'b0001};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,4'b0000,32'h22,4'd2,1'b1,1'b1,1'b0, 1'b1,1'b0,32'h11,4'd1,1'b1,1'b0,1'b1,4'b0001};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b1,4'b0010,32'h33,4'd7,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h11,4'd1,1'b1,1'b0,1'b1,4'b0001};
      vecs[8]  = '{1'b1,1'b0,1'b1,1'b1,4'b0010,32'h33,4'd7,1'b0,1'b0,1'b1, 1'b1,1'b1,32'h22,4'd2,1'b1,1'b1,1'b0,4'b0001};
      vecs[9]  = '{1'b1,1'b0,1'b1,1'b1,4'b0010,32'h33,4'd7,1'b0,1'b0,1'b1, 1'b1,1'b1,32'h33,4'd7,1'b0,1'b0,1'b1,4'b0010};
      vecs[10] = '{1'b0,1'b0,1'b1,1'b0,4'b0000,32'h00,4'd0,1'b0,1'b0,1'b0, 1'b0,1'b1,32'h00,4'd0,1'b0,1'b0,1'b0,4'b0010};

      // Reset state
      rst = 1'b1;
      drive('{default: '0});
      @(posedge clk); @(posedge clk); #1;
      check("reset mem_valid", {31'b0, bus.mem_valid}, 32'd0);
      check("reset exe_ready", {31'b0, bus.exe_ready}, 32'd1);
      check("reset status_reg", {28'b0, status_reg}, 32'd0);
      check("reset carry_out", {31'b0, carry_out}, 32'd0);
      check("reset stall_count", {16'b0, stall_count}, 32'd0);
      check("reset mem_alu_result", bus.mem_alu_result, 32'd0);
      check("reset mem_ctrl", {29'b0, bus.mem_wb_en, bus.mem_r_en_o, bus.mem_w_en_o}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i]);
         @(posedge clk); #1;
         $display("vec %0d: mv=%0b er=%0b res=%h dst=%0d st=%b", i, bus.mem_valid, bus.exe_ready,
                  bus.mem_alu_result, bus.mem_dest, status_reg);
         check($sformatf("v%0d mem_valid", i), {31'b0, bus.mem_valid}, {31'b0, vecs[i].x_mv});
         check($sformatf("v%0d exe_ready", i), {31'b0, bus.exe_ready}, {31'b0, vecs[i].x_er});
         check($sformatf("v%0d ctrl", i), {29'b0, bus.mem_wb_en, bus.mem_r_en_o, bus.mem_w_en_o},
               {29'b0, vecs[i].x_wb, vecs[i].x_re, vecs[i].x_we});
         check($sformatf("v%0d status_reg", i), {28'b0, status_reg}, {28'b0, vecs[i].x_st});
         check($sformatf("v%0d carry_out", i), {31'b0, carry_out}, {31'b0, vecs[i].x_st[2]});
         if (vecs[i].x_mv) begin
            check($sformatf("v%0d mem_alu_result", i), bus.mem_alu_result, vecs[i].x_res);
            check($sformatf("v%0d mem_val_rm", i), bus.mem_val_rm, ~vecs[i].x_res);
            check($sformatf("v%0d mem_dest", i), {28'b0, bus.mem_dest}, {28'b0, vecs[i].x_dst});
         end
      end

      // Fresh reset, fill both entries, then hold EXE stalled for 10 cycles
      rst = 1'b1;
      drive('{default: '0});
      @(posedge clk); #1;
      rst = 1'b0;
      drive('{ev: 1'b1, sb: 1'b1, ast: 4'b1010, res: 32'h44, dst: 4'd8, wb: 1'b1, default: '0});
      @(posedge clk); #1;
      drive('{ev: 1'b1, res: 32'h55, dst: 4'd9, wb: 1'b1, default: '0});
      @(posedge clk); #1;
      $display("fill: mv=%0b er=%0b st=%b", bus.mem_valid, bus.exe_ready, status_reg);
      check("fill exe_ready", {31'b0, bus.exe_ready}, 32'd0);
      check("fill status_reg", {28'b0, status_reg}, 32'b1010);
      check("fill head", bus.mem_alu_result, 32'h44);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      $display("stall: stall_count=%0d", stall_count);
`ifdef EXE_MEM_STALL_CNT_EN
      check("stall_count after 10", {16'b0, stall_count}, 32'd10);
`else
      check("stall_count disabled", {16'b0, stall_count}, 32'd0);
`endif
      check("stall head held", bus.mem_alu_result, 32'h44);

      // Asynchronous reset mid-cycle while in TWO
      #2 rst = 1'b1;
      #1;
      $display("async rst: mv=%0b er=%0b st=%b", bus.mem_valid, bus.exe_ready, status_reg);
      check("async rst mem_valid", {31'b0, bus.mem_valid}, 32'd0);
      check("async rst exe_ready", {31'b0, bus.exe_ready}, 32'd1);
      check("async rst status_reg", {28'b0, status_reg}, 32'd0);
      check("async rst stall_count", {16'b0, stall_count}, 32'd0);
      check("async rst ctrl", {29'b0, bus.mem_wb_en, bus.mem_r_en_o, bus.mem_w_en_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/exe_mem_stage_buf.md
Name: exe_mem_stage_buf

Overview:
- EXE-to-MEM pipeline boundary of the ARM core.
- Captures the ALU result and control of each instruction leaving EXE and holds the architectural NZCV status register.
- Supplies the carry flag back to the ALU `cin` input.
- Two-entry skid buffer, so EXE sees a registered ready while MEM (SRAM access) may stall.

Parameters:
- REG_LEN, 32: data width of ALU result and store data.
- DEST_LEN, 4: width of the destination register index.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- exe_valid  in  1  EXE presents an instruction.
- exe_ready  out  1  buffer can accept; registered.
- flush  in  1  branch taken; current EXE instruction is killed.
- alu_result  in  REG_LEN  ALU output.
- alu_status  in  4  ALU flags, order {Z,C,N,V}.
- s_bit  in  1  instruction updates status.
- wb_en, mem_r_en, mem_w_en  in  1 each  control bits.
- dest  in  DEST_LEN  writeback register index.
- val_rm  in  REG_LEN  store data.
- mem_valid  out  1  head entry valid.
- mem_ready  in  1  MEM consumes head this cycle.
- mem_alu_result, mem_val_rm  out  REG_LEN  head entry fields.
- mem_wb_en, mem_r_en_o, mem_w_en_o  out  1 each  head control bits.
- mem_dest  out  DEST_LEN  head entry destination.
- status_reg  out  4  architectural {Z,C,N,V}.
- carry_out  out  1  equals status_reg[2]; drives ALU `cin`.
- stall_count  out  16  see Optional Feature.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=EMPTY, exe_ready=1, mem_valid=0, status_reg=4'b0, stall_count=0.
  - All mem_* data and control outputs are 0.
- Events:
  - accept = exe_valid & exe_ready & ~flush.
  - drain = mem_valid & mem_ready.
- Flush: with exe_valid=1 the instruction is discarded. No entry is written and status is not updated. Already buffered entries are unaffected.
- Status register:
  - On accept with s_bit=1, status_reg <= alu_status at that edge.
  - Exactly one update per accepted instruction, even if EXE holds inputs for several cycles.
  - carry_out is combinational from status_reg.
- State machine (entries: head H, skid S):
  - EMPTY:
    - accept → ONE; H loaded.
    - otherwise stay.
  - ONE:
    - accept & drain → ONE; H reloaded.
    - accept & ~drain → TWO; S loaded.
    - drain only → EMPTY.
  - TWO:
    - exe_ready=0, so no accept.
    - drain → ONE; S promoted to H.
    - otherwise hold.
- exe_ready is registered: 1 in EMPTY and ONE, 0 in TWO, updated with the state.
- Latency: an instruction accepted at edge k appears on mem_* after edge k (visible in cycle k+1).
- mem_valid = (state != EMPTY).
- Output hold: mem_* outputs are stable while mem_valid & ~mem_ready.
- Head contents when mem_valid=0:
  - Control bits (wb_en, r_en, w_en) are forced to 0.
  - Data fields are don't-care.
- Reset during operation: all entries dropped, status cleared, no partial update.

Optional Feature:
- Macro: EXE_MEM_STALL_CNT_EN.
- Defined:
  - stall_count increments each cycle exe_valid & ~exe_ready & ~flush.
  - Saturates at 16'hFFFF.
  - Cleared only by rst.
- Undefined: stall_count is constant 0 and no counter flops are inferred.

Test Plan:
- Reset, then exe_valid=1, alu_result=32'h0000_0005, dest=3, wb_en=1, mem_ready=1 → next cycle mem_valid=1, mem_alu_result=5, mem_dest=3, exe_ready stays 1.
- ADDS producing alu_status=4'b0100 with s_bit=1 → status_reg=4'b0100 and carry_out=1 one edge later; a following s_bit=0 instruction leaves it unchanged.
- mem_ready=0 and three back-to-back instructions A, B, C:
  - After A and B, exe_ready=0; C is held, and status is not updated for C until accepted.
  - mem_ready=1 drains A, B, C in order.
- flush=1 with exe_valid=1 and s_bit=1, alu_status=4'b1000 → no entry, status_reg unchanged, mem_valid unaffected.
- Assert rst mid-run with state TWO → immediately mem_valid=0, exe_ready=1, status_reg=0.
- With EXE_MEM_STALL_CNT_EN defined, hold TWO for 10 cycles with exe_valid=1 → stall_count=10; undefined → stall_count=0.
